// File: rtl/cnn_pkg.sv
// cnn_pkg: shared geometry, widths and FSM state type for the
// simpleCNN sequencing controller and its argmax helper.
package cnn_pkg;

    localparam int IMG_H   = 10;
    localparam int IMG_W   = 20;
    localparam int K       = 3;
    localparam int NCLASS  = 10;
    localparam int SCORE_W = 16;

    localparam int IMG_N    = IMG_H * IMG_W;
    localparam int WIN_N    = K * K;
    localparam int WIN_ROWS = IMG_H - K + 1;
    localparam int WIN_COLS = IMG_W - K + 1;
    localparam int NWIN     = WIN_ROWS * WIN_COLS;

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int CLS_W = $clog2(NCLASS);
    localparam int IDX_W = $clog2(IMG_N);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(WIN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIN_COLS - 1);
    localparam logic [CLS_W-1:0] CLS_MAX = CLS_W'(NCLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_CONV,
        S_REQ,
        S_WAIT_SCORE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/cnn_seq_ctrl_if.sv
// cnn_seq_ctrl_if: start/image, window stream, conv-done, score poll
// and result signals. master = controller, slave = environment.
interface cnn_seq_ctrl_if;
    import cnn_pkg::*;

    logic                      START;
    logic [IMG_N-1:0]          IMGIN;
    logic                      BUSY;
    logic                      WIN_VALID;
    logic                      WIN_READY;
    logic [WIN_N-1:0]          WIN_DATA;
    logic [ROW_W-1:0]          WIN_ROW;
    logic [COL_W-1:0]          WIN_COL;
    logic                      WIN_LAST;
    logic                      CONV_DONE;
    logic                      SCORE_REQ;
    logic [CLS_W-1:0]          SCORE_CLS;
    logic                      SCORE_VALID;
    logic signed [SCORE_W-1:0] SCORE;
    logic                      DONE;
    logic [CLS_W-1:0]          OUT;

    modport master (
        input  START, IMGIN, WIN_READY, CONV_DONE,
        input  SCORE_VALID, SCORE,
        output BUSY, WIN_VALID, WIN_DATA, WIN_ROW,
        output WIN_COL, WIN_LAST, SCORE_REQ,
        output SCORE_CLS, DONE, OUT
    );

    modport slave (
        output START, IMGIN, WIN_READY, CONV_DONE,
        output SCORE_VALID, SCORE,
        input  BUSY, WIN_VALID, WIN_DATA, WIN_ROW,
        input  WIN_COL, WIN_LAST, SCORE_REQ,
        input  SCORE_CLS, DONE, OUT
    );

endinterface

// File: rtl/cnn_argmax.sv
// cnn_argmax: running best-score tracker across class scores.
// Ports: clk, rst (sync high), clr, upd, cls, score in; best out.
module cnn_argmax
    import cnn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      upd,
    input  logic [CLS_W-1:0]          cls,
    input  logic signed [SCORE_W-1:0] score,
    output logic [CLS_W-1:0]          best
);

    logic signed [SCORE_W-1:0] best_score;
    logic [CLS_W-1:0]          best_cls;
    logic                      take;

    // Class 0 seeds the tracker; strict > keeps the lower index on ties.
    assign take = (cls == '0) || (score > best_score);

    // Winner including the score presented this cycle, so the caller
    // can register the final result on the same edge as the update.
    assign best = (upd && take) ? cls : best_cls;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            best_score <= '0;
            best_cls   <= '0;
        end else if (upd && take) begin
            best_score <= score;
            best_cls   <= cls;
        end
    end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl: latches an image, streams all 3x3 windows, polls one
// score per class and reports the argmax. Ports: CLK, RST, bus.
module cnn_seq_ctrl
    import cnn_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    cnn_seq_ctrl_if.master bus
);

    state_t           state;
    logic [IMG_N-1:0] img;
    logic [IMG_N-1:0] src;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_col;
    logic             nxt_last;
    logic [WIN_N-1:0] nxt_data;
    logic [IDX_W-1:0] idx;
    logic [CLS_W-1:0] cls;
    logic             busy;
    logic             win_valid;
    logic [WIN_N-1:0] win_data;
    logic             win_last;
    logic             score_req;
    logic             done;
    logic [CLS_W-1:0] out_cls;
    logic             clr;
    logic             upd;
    logic [CLS_W-1:0] best;

    // The first window is sliced straight from IMGIN on the START edge.
    assign src = (state == S_IDLE) ? bus.IMGIN : img;

    always_comb begin
        nxt_row = '0;
        nxt_col = '0;
        if (state == S_STREAM && !win_last) begin
            if (col == COL_MAX) begin
                nxt_row = row + 1'b1;
            end else begin
                nxt_row = row;
                nxt_col = col + 1'b1;
            end
        end
    end

    assign nxt_last = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);

    always_comb begin
        nxt_data = '0;
        idx      = '0;
        for (int k = 0; k < WIN_N; k++) begin
            idx = IDX_W'((int'(nxt_row) + k / K) * IMG_W
                         + int'(nxt_col) + k % K);
            nxt_data[k] = src[idx];
        end
    end

    assign clr = (state == S_IDLE) && bus.START;
    assign upd = (state == S_WAIT_SCORE) && bus.SCORE_VALID;

    cnn_argmax u_argmax (
        .clk   (CLK),
        .rst   (RST),
        .clr   (clr),
        .upd   (upd),
        .cls   (cls),
        .score (bus.SCORE),
        .best  (best)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            img       <= '0;
            row       <= '0;
            col       <= '0;
            cls       <= '0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_last  <= 1'b0;
            score_req <= 1'b0;
            done      <= 1'b0;
            out_cls   <= '0;
        end else begin
            score_req <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        img       <= bus.IMGIN;
                        row       <= '0;
                        col       <= '0;
                        cls       <= '0;
                        busy      <= 1'b1;
                        win_valid <= 1'b1;
                        win_data  <= nxt_data;
                        win_last  <= 1'b0;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.WIN_READY) begin
                        if (win_last) begin
                            win_valid <= 1'b0;
                            win_data  <= '0;
                            win_last  <= 1'b0;
                            row       <= '0;
                            col       <= '0;
                            state     <= S_WAIT_CONV;
                        end else begin
                            row      <= nxt_row;
                            col      <= nxt_col;
                            win_data <= nxt_data;
                            win_last <= nxt_last;
                        end
                    end
                end
                S_WAIT_CONV: begin
                    if (bus.CONV_DONE) begin
                        score_req <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT_SCORE;
                end
                S_WAIT_SCORE: begin
                    if (bus.SCORE_VALID) begin
                        if (cls == CLS_MAX) begin
                            out_cls <= best;
                            done    <= 1'b1;
                            state   <= S_FINISH;
                        end else begin
                            cls       <= cls + 1'b1;
                            score_req <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    cls   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy;
    assign bus.WIN_VALID = win_valid;
    assign bus.WIN_DATA  = win_data;
    assign bus.WIN_ROW   = row;
    assign bus.WIN_COL   = col;
    assign bus.WIN_LAST  = win_last;
    assign bus.SCORE_REQ = score_req;
    assign bus.SCORE_CLS = cls;
    assign bus.DONE      = done;
    assign bus.OUT       = out_cls;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl: scoreboard bench for cnn_seq_ctrl with a
// cycle-level engine/score responder model.
module tb_cnn_seq_ctrl;
    import cnn_pkg::*;

    typedef struct packed {
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        logic [WIN_N-1:0] d;
        logic             last;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_seq_ctrl_if bus ();

    cnn_seq_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    int               errors = 0;
    int               checks = 0;
    win_t             win_q[$];
    logic [CLS_W-1:0] res_q[$];
    int               scores[NCLASS];
    int               nz_cnt;
    logic [WIN_N-1:0] d38;
    logic [CLS_W-1:0] last_out;
    logic [IMG_N-1:0] img;
    logic [IMG_N-1:0] img_r;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, bus.BUSY, bus.WIN_VALID, bus.WIN_DATA,
                bus.WIN_ROW, bus.WIN_COL, bus.WIN_LAST,
                bus.SCORE_REQ, bus.SCORE_CLS, bus.DONE, bus.OUT};
    endfunction

    function automatic logic [WIN_N-1:0] model_win(
        input logic [IMG_N-1:0] im, input int r, input int c);
        logic [WIN_N-1:0] d = '0;
        for (int k = 0; k < WIN_N; k++)
            d[k] = im[(r + k / 3) * IMG_W + c + k % 3];
        return d;
    endfunction

    function automatic logic [CLS_W-1:0] model_argmax();
        int b = 0;
        for (int i = 1; i < NCLASS; i++)
            if (scores[i] > scores[b]) b = i;
        return CLS_W'(b);
    endfunction

    task automatic run(input logic [IMG_N-1:0] im, input int stall,
                       input int lat, input bit inject,
                       input int rst_at, input bit timing);
        int   cyc, nacc, cnt, exp_cls, req_cls, nbad;
        bit   conv_next, hold, fin;
        logic [18:0] prev, cur;
        win_t w;
        cyc = 0; nacc = 0; cnt = 0; exp_cls = 0; req_cls = 0;
        conv_next = 0; hold = 0; fin = 0; prev = '0;
        nz_cnt = 0; d38 = '0;
        for (int r = 0; r < WIN_ROWS; r++)
            for (int c = 0; c < WIN_COLS; c++)
                win_q.push_back('{r: ROW_W'(r), c: COL_W'(c),
                                  d: model_win(im, r, c),
                                  last: (r == WIN_ROWS - 1 &&
                                         c == WIN_COLS - 1)});
        res_q.push_back(model_argmax());
        bus.IMGIN = im;
        bus.START = 1'b1;
        bus.WIN_READY = 1'b0;
        bus.CONV_DONE = 1'b0;
        bus.SCORE_VALID = 1'b0;
        bus.SCORE = '0;
        @(posedge clk); #1;
        cyc = 1;
        bus.IMGIN = ~im;
        while (!fin && cyc < 3000) begin
            bus.START = 1'b0;
            bus.CONV_DONE = conv_next;
            conv_next = 0;
            bus.SCORE_VALID = 1'b0;
            if (timing && cyc == 1)
                check("first_valid", bus.WIN_VALID, 1);
            if (timing && cyc == 145)
                check("wait_conv", {bus.BUSY, bus.WIN_VALID}, 2'b10);
            cur = {bus.WIN_ROW, bus.WIN_COL, bus.WIN_DATA, bus.WIN_LAST};
            if (hold) check("stall_hold", cur, prev);
            if (rst_at >= 0 && bus.WIN_VALID && nacc == rst_at) begin
                rst = 1'b1;
                bus.WIN_READY = 1'b0;
                bus.CONV_DONE = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_outs", outs(), 0);
                nbad = 0;
                repeat (200) begin
                    @(posedge clk); #1;
                    if (bus.DONE || bus.BUSY) nbad++;
                end
                check("rst_no_done", nbad, 0);
                win_q.delete();
                res_q.delete();
                fin = 1;
                break;
            end
            bus.WIN_READY = ($urandom_range(99) >= stall);
            hold = bus.WIN_VALID && !bus.WIN_READY;
            prev = cur;
            if (bus.WIN_VALID && bus.WIN_READY) begin
                if (win_q.size() == 0) begin
                    check("win_extra", nacc, NWIN);
                end else begin
                    w = win_q.pop_front();
                    check("win_row", bus.WIN_ROW, w.r);
                    check("win_col", bus.WIN_COL, w.c);
                    check("win_data", bus.WIN_DATA, w.d);
                    check("win_last", bus.WIN_LAST, w.last);
                    if (bus.WIN_DATA != '0) nz_cnt++;
                    if (w.r == 3 && w.c == 8) d38 = bus.WIN_DATA;
                    if (w.last) conv_next = 1;
                end
                nacc++;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.SCORE_VALID = 1'b1;
                    bus.SCORE = SCORE_W'(scores[req_cls]);
                end
            end
            if (bus.SCORE_REQ) begin
                check("score_cls", bus.SCORE_CLS, exp_cls);
                if (exp_cls < NCLASS) req_cls = exp_cls;
                exp_cls++;
                cnt = lat;
            end
            if (inject && bus.WIN_VALID && nacc == 20) begin
                bus.START = 1'b1;
                bus.CONV_DONE = 1'b1;
                bus.SCORE_VALID = 1'b1;
                bus.SCORE = 16'sh7fff;
            end
            if (inject && cnt > 0) bus.START = 1'b1;
            if (bus.DONE) begin
                if (res_q.size() == 0) check("done_extra", 1, 0);
                else check("out", bus.OUT, res_q.pop_front());
                last_out = bus.OUT;
                // START sampled at edge 0; DONE occupies cycle 166,
                // i.e. 167 cycles counting the START cycle.
                if (timing) check("done_cycle", cyc, 166);
                bus.START = 1'b1;
                @(posedge clk); #1;
                check("idle_after_done",
                      {bus.BUSY, bus.WIN_VALID, bus.DONE}, 0);
                check("out_hold", bus.OUT, last_out);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.START = 1'b0;
        bus.WIN_READY = 1'b0;
        bus.CONV_DONE = 1'b0;
        bus.SCORE_VALID = 1'b0;
        if (!fin) check("timeout", cyc, 0);
        if (rst_at < 0) begin
            check("win_left", win_q.size(), 0);
            check("cls_count", exp_cls, NCLASS);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.START = 1'b0;
        bus.IMGIN = '0;
        bus.WIN_READY = 1'b0;
        bus.CONV_DONE = 1'b0;
        bus.SCORE_VALID = 1'b0;
        bus.SCORE = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NCLASS; i++) scores[i] = 10 * i;
        img = '1;
        run(img, 0, 1, 0, -1, 1);
        check("ones_out", last_out, 9);

        img = '0;
        img[4 * IMG_W + 9] = 1'b1;
        run(img, 0, 1, 0, -1, 1);
        check("pix_nz", nz_cnt, 9);
        check("pix_3_8", d38, 9'b000010000);

        for (int i = 0; i < IMG_N; i++) img_r[i] = 1'($urandom_range(1));
        for (int i = 0; i < NCLASS; i++)
            scores[i] = int'($urandom_range(2000)) - 1000;
        run(img_r, 50, 2, 0, -1, 0);

        scores = '{5, -3, 12, 12, 0, 0, 0, 0, 0, 0};
        run(img_r, 0, 3, 0, -1, 0);
        check("tie_out", last_out, 2);

        for (int i = 0; i < NCLASS; i++) scores[i] = -100;
        run(img_r, 0, 1, 0, -1, 0);
        check("neg_out", last_out, 0);

        for (int i = 0; i < NCLASS; i++)
            scores[i] = int'($urandom_range(2000)) - 1000;
        run(img_r, 30, 2, 1, -1, 0);

        run(img_r, 0, 1, 0, 50, 0);

        for (int i = 0; i < NCLASS; i++) scores[i] = 10 * i;
        img = '1;
        run(img, 0, 1, 0, -1, 1);
        check("fresh_out", last_out, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_seq_ctrl.md
# cnn_seq_ctrl

Sequencing controller for the simpleCNN inference path. On START it latches a 10x20 binary image and streams every 3x3 convolution window to the conv/MAC engine over a valid/ready handshake. It then polls the engine for one score per class and reports the argmax class on OUT with a one-cycle DONE pulse. It sits between the image source and the conv engine and owns all CNN control sequencing.

## Interface
- IMG_H, 10, image rows
- IMG_W, 20, image columns; IMGIN width = IMG_H*IMG_W = 200
- K, 3, window edge; window positions = (IMG_H-K+1)*(IMG_W-K+1) = 8*18 = 144
- NCLASS, 10, number of classes
- SCORE_W, 16, signed class score width

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  start pulse; honoured only in IDLE
- IMGIN  in  200  image; pixel (r,c) = IMGIN[r*IMG_W+c]
- BUSY  out  1  high in every state except IDLE
- WIN_VALID  out  1  window presented
- WIN_READY  in  1  engine accepts window
- WIN_DATA  out  9  bit k = pixel (row+k/3, col+k%3)
- WIN_ROW  out  4  window top row, 0..7
- WIN_COL  out  5  window left column, 0..17
- WIN_LAST  out  1  high with the final window (7,17)
- CONV_DONE  in  1  engine pulse: all windows processed
- SCORE_REQ  out  1  one-cycle score request
- SCORE_CLS  out  4  class being requested
- SCORE_VALID  in  1  score returned for SCORE_CLS
- SCORE  in  SCORE_W  signed score
- DONE  out  1  one-cycle result pulse
- OUT  out  4  argmax class, held until the next DONE

## Operation
- States: IDLE -> STREAM -> WAIT_CONV -> REQ -> WAIT_SCORE -> (REQ | FINISH) -> IDLE.
- IDLE: START=1 latches IMGIN into an internal register, clears row/col, cls and the best tracker, then enters STREAM. START in any other state is ignored. IMGIN changes after the latch have no effect.
- STREAM: WIN_VALID=1. WIN_DATA/ROW/COL come from the latched image.
  - Advance on WIN_VALID&&WIN_READY only, in row-major order (col 0..17, then row+1).
  - Outputs stay stable while WIN_READY=0.
  - Acceptance of (7,17) moves the FSM to WAIT_CONV.
- WAIT_CONV: wait for CONV_DONE. CONV_DONE in any other state is ignored.
- REQ: SCORE_REQ=1 for exactly one cycle with SCORE_CLS=cls, then go to WAIT_SCORE.
- WAIT_SCORE: on SCORE_VALID, update best if cls==0 or SCORE > best_score (signed compare). Ties keep the lower class index.
  - If cls==NCLASS-1, go to FINISH; otherwise cls+1 and go to REQ.
  - SCORE_VALID outside WAIT_SCORE is ignored.
- FINISH: OUT<=best_cls, DONE=1 for one cycle, then IDLE.
- Reset values: state IDLE; all outputs 0, including OUT=0, SCORE_CLS=0, WIN_* =0.
- RST mid-operation: IDLE on the next edge. Any window/score in flight is discarded, no DONE is produced, and OUT is reset to 0.

## Timing
- START sampled at edge 0. WIN_VALID is high from cycle 1.
- With WIN_READY tied high, windows occupy cycles 1..144, and WAIT_CONV begins at cycle 145.
- CONV_DONE seen in cycle t gives SCORE_REQ in cycle t+1.
- Each class costs 1 REQ cycle plus the score latency; the minimum is 2 cycles per class when SCORE_VALID arrives the cycle after SCORE_REQ.
- DONE is asserted the cycle after the final SCORE_VALID. OUT is updated on the same edge DONE rises.
- Minimum START-to-DONE with immediate responders: 1+144+1+20+1 = 167 cycles.
- START coincident with DONE is ignored, because the FSM is in FINISH. START on the cycle after DONE is accepted.

## Structure
- Package cnn_pkg holds IMG_H, IMG_W, K, NCLASS, SCORE_W, the derived window count/row/col widths, and the state enum typedef.
- One sub-module, cnn_argmax: holds best_score and best_cls, with clear/update/compare logic. The window slicing stays inline in cnn_seq_ctrl.

## Test plan
- Image = all ones, WIN_READY=1, CONV_DONE one cycle after WIN_LAST, immediate scores equal to 10*cls -> 144 windows each with WIN_DATA=9'h1FF, WIN_LAST only at (7,17), DONE at cycle 167, OUT=9.
- Single pixel set at (4,9) -> WIN_DATA=9'b000010000 only at window (3,8). The pixel also appears in 8 other windows at the matching bit positions, and every remaining window is 0.
- Random WIN_READY stalls (50%) -> WIN_DATA/ROW/COL stable throughout each stall, no window skipped or duplicated, order identical to the unstalled case.
- Scores {5,-3,12,12,0,...} with SCORE_VALID 3 cycles after each SCORE_REQ -> OUT=2 (tie resolved to the lower index). Scores all -100 -> OUT=0.
- START pulses during STREAM and WAIT_SCORE, plus stray CONV_DONE/SCORE_VALID in STREAM -> ignored, and the result matches the clean run.
- RST asserted mid-stream at window 50 -> the next cycle is IDLE with all outputs 0 and no DONE. A fresh START then completes normally.
